// File: rtl/gcn_mem_pkg.sv
// Shared types and geometry for the GCN memory responder: load-state enum,
// matrix dimensions and the packed row type returned to the core.
package gcn_mem_pkg;

   localparam int FEATURE_COLS    = 96;
   localparam int FEATURE_ROWS    = 6;
   localparam int WEIGHT_ROWS     = 96;
   localparam int WEIGHT_COLS     = 3;
   localparam int DATA_WIDTH      = 5;
   localparam int ADDRESS_WIDTH   = 13;
   localparam int FEATURE_BASE    = 512;
   localparam int COO_NUM_OF_COLS = 6;
   localparam int COO_BW          = 3;

   // Counter widths cover the largest inner (96) and outer (6) extents.
   localparam int INNER_W = $clog2(WEIGHT_ROWS);
   localparam int OUTER_W = $clog2(FEATURE_ROWS);
   localparam int WC_IW   = $clog2(WEIGHT_COLS);
   localparam int FR_IW   = $clog2(FEATURE_ROWS);

   typedef enum logic [1:0] {
      LOAD_W = 2'd0,
      LOAD_F = 2'd1,
      LOAD_C = 2'd2,
      SERVE  = 2'd3
   } state_t;

   // Element k of a row is row[k]; index 0 is the most significant slice.
   typedef logic [0:WEIGHT_ROWS-1][DATA_WIDTH-1:0] row_t;

endpackage

// File: rtl/gcn_load_counter.sv
// Two-level load counter: inner index wraps into the outer index; o_tc flags
// the increment that wraps both, i.e. the last element of a load phase.
module gcn_load_counter #(
   parameter int INNER_W = 7,
   parameter int OUTER_W = 3
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_clear,
   input  logic               i_inc,
   input  logic [INNER_W-1:0] i_inner_max,
   input  logic [OUTER_W-1:0] i_outer_max,
   output logic [INNER_W-1:0] o_inner,
   output logic [OUTER_W-1:0] o_outer,
   output logic               o_tc
);

   logic [INNER_W-1:0] r_inner;
   logic [OUTER_W-1:0] r_outer;
   logic               w_inner_last;
   logic               w_outer_last;

   assign w_inner_last = (r_inner == i_inner_max);
   assign w_outer_last = (r_outer == i_outer_max);
   assign o_tc         = i_inc && w_inner_last && w_outer_last;
   assign o_inner      = r_inner;
   assign o_outer      = r_outer;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_inner <= '0;
         r_outer <= '0;
      end else if (i_clear) begin
         r_inner <= '0;
         r_outer <= '0;
      end else if (i_inc) begin
         if (w_inner_last) begin
            r_inner <= '0;
            r_outer <= w_outer_last ? '0 : r_outer + 1'b1;
         end else begin
            r_inner <= r_inner + 1'b1;
         end
      end
   end

endmodule

// File: rtl/gcn_mem_responder.sv
// Memory responder behind the GCN read port: loads weights, features and the
// COO edge list from a host stream, then serves registered row reads.
module gcn_mem_responder
   import gcn_mem_pkg::*;
(
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_load_valid,
   input  logic [DATA_WIDTH-1:0]    i_load_data,
   output logic                     o_load_ready,
   input  logic                     i_reload,
   output logic                     o_mem_ready,
   input  logic                     i_enable_read,
   input  logic [ADDRESS_WIDTH-1:0] i_read_address,
   output row_t                     o_data_out,
   input  logic [COO_BW-1:0]        i_coo_address,
   output logic [2*COO_BW-1:0]      o_coo_out,
   output logic                     o_rd_err,
   output state_t                   o_dbg_state
);

   state_t r_state;
   state_t w_next_state;

   logic               w_accept;
   logic               w_write;
   logic               w_tc;
   logic               w_serve;
   logic [INNER_W-1:0] w_inner;
   logic [OUTER_W-1:0] w_outer;
   logic [INNER_W-1:0] w_inner_max;
   logic [OUTER_W-1:0] w_outer_max;

   row_t              r_weight  [0:WEIGHT_COLS-1];
   row_t              r_feature [0:FEATURE_ROWS-1];
   logic [COO_BW-1:0] r_coo_src [0:COO_NUM_OF_COLS-1];
   logic [COO_BW-1:0] r_coo_dst [0:COO_NUM_OF_COLS-1];

   row_t r_data_out;
   logic r_mem_ready;
   logic r_rd_err;

   logic                     w_feat_sel;
   logic [ADDRESS_WIDTH-1:0] w_feat_idx;
   logic                     w_rd_oob;
   logic                     w_coo_oob;

   // Load handshake: an element transfers on a clock edge where
   // i_load_valid && o_load_ready; o_load_ready depends only on state,
   // and a same-cycle i_reload discards the transfer.
   assign w_serve      = (r_state == SERVE);
   assign o_load_ready = !w_serve;
   assign w_accept     = i_load_valid && o_load_ready;
   assign w_write      = w_accept && !i_reload;

   always_comb begin
      w_inner_max = INNER_W'(WEIGHT_ROWS - 1);
      w_outer_max = OUTER_W'(WEIGHT_COLS - 1);
      case (r_state)
         LOAD_F: begin
            w_inner_max = INNER_W'(FEATURE_COLS - 1);
            w_outer_max = OUTER_W'(FEATURE_ROWS - 1);
         end
         LOAD_C: begin
            w_inner_max = INNER_W'(COO_NUM_OF_COLS - 1);
            w_outer_max = OUTER_W'(1);
         end
         default: ;
      endcase
   end

   gcn_load_counter #(
      .INNER_W (INNER_W),
      .OUTER_W (OUTER_W)
   ) u_load_counter (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_clear     (i_reload),
      .i_inc       (w_write),
      .i_inner_max (w_inner_max),
      .i_outer_max (w_outer_max),
      .o_inner     (w_inner),
      .o_outer     (w_outer),
      .o_tc        (w_tc)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= LOAD_W;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (i_reload) begin
         w_next_state = LOAD_W;
      end else begin
         case (r_state)
            LOAD_W:  if (w_tc) w_next_state = LOAD_F;
            LOAD_F:  if (w_tc) w_next_state = LOAD_C;
            LOAD_C:  if (w_tc) w_next_state = SERVE;
            default: w_next_state = SERVE;
         endcase
      end
   end

   // Storage is deliberately left unreset; a fresh load overwrites it.
   always_ff @(posedge i_clk) begin
      if (w_write) begin
         case (r_state)
            LOAD_W: r_weight[w_outer[WC_IW-1:0]][w_inner] <= i_load_data;
            LOAD_F: r_feature[w_outer[FR_IW-1:0]][w_inner] <= i_load_data;
            LOAD_C: begin
               if (w_outer[0]) begin
                  r_coo_dst[w_inner[COO_BW-1:0]] <= i_load_data[COO_BW-1:0];
               end else begin
                  r_coo_src[w_inner[COO_BW-1:0]] <= i_load_data[COO_BW-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign w_feat_sel = (i_read_address >= ADDRESS_WIDTH'(FEATURE_BASE));
   assign w_feat_idx = i_read_address - ADDRESS_WIDTH'(FEATURE_BASE);
   assign w_rd_oob   = w_feat_sel ? (w_feat_idx >= ADDRESS_WIDTH'(FEATURE_ROWS))
                                  : (i_read_address >= ADDRESS_WIDTH'(WEIGHT_COLS));
   assign w_coo_oob  = (i_coo_address >= COO_BW'(COO_NUM_OF_COLS));

   // rd_err is sticky; only reset or reload clears it.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_data_out  <= '0;
         r_mem_ready <= 1'b0;
         r_rd_err    <= 1'b0;
      end else if (i_reload) begin
         r_data_out  <= '0;
         r_mem_ready <= 1'b0;
         r_rd_err    <= 1'b0;
      end else begin
         r_mem_ready <= w_serve;
         if (w_serve && i_enable_read) begin
            if (w_rd_oob) begin
               r_data_out <= '0;
               r_rd_err   <= 1'b1;
            end else if (w_feat_sel) begin
               r_data_out <= r_feature[w_feat_idx[FR_IW-1:0]];
            end else begin
               r_data_out <= r_weight[i_read_address[WC_IW-1:0]];
            end
         end
         if (w_serve && w_coo_oob) begin
            r_rd_err <= 1'b1;
         end
      end
   end

   always_comb begin
      o_coo_out = '0;
      if (w_serve && !w_coo_oob) begin
         o_coo_out = {r_coo_src[i_coo_address], r_coo_dst[i_coo_address]};
      end
   end

   assign o_data_out  = r_data_out;
   assign o_mem_ready = r_mem_ready;
   assign o_rd_err    = r_rd_err;
   assign o_dbg_state = r_state;

endmodule
